// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared register-bank sizes and data/address types
package reg_bank_pkg;
  localparam int REG_WIDTH  = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);
  typedef logic [REG_WIDTH-1:0]  reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_bank_read_mux.sv
// reg_bank_read_mux: M:1 N-bit combinational read selector for one read port
module reg_bank_read_mux #(
  parameter int N = 32,
  parameter int M = 32
) (
  input  logic [N-1:0]         regs [M],
  input  logic [$clog2(M)-1:0] sel,
  output logic [N-1:0]         data
);
  assign data = regs[sel];
endmodule

// File: rtl/n_reg_bank.sv
// n_reg_bank: M x N register file, two async read ports, one sync write port; REG_BANK_ZERO_REG_EN hardwires register 0 to zero
module n_reg_bank
  import reg_bank_pkg::*;
#(
  parameter int N = REG_WIDTH,
  parameter int M = REG_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         Wdata,
  input  logic [$clog2(M)-1:0] Wreg,
  input  logic [$clog2(M)-1:0] Rreg1,
  input  logic [$clog2(M)-1:0] Rreg2,
  output logic [N-1:0]         Rdata1,
  output logic [N-1:0]         Rdata2,
  input  logic                 RegWrite
);
  logic [N-1:0] regs_q [M];
  logic [N-1:0] regs_d [M];
  // next array contents: single-entry write when enabled
  always_comb begin
    regs_d = regs_q;
`ifdef REG_BANK_ZERO_REG_EN
    if (RegWrite && Wreg != '0) regs_d[Wreg] = Wdata;
    regs_d[0] = '0;
`else
    if (RegWrite) regs_d[Wreg] = Wdata;
`endif
  end
  // storage update; reset clears every entry and overrides any write
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  reg_bank_read_mux #(.N(N), .M(M)) u_rd1 (.regs(regs_q), .sel(Rreg1), .data(Rdata1));
  reg_bank_read_mux #(.N(N), .M(M)) u_rd2 (.regs(regs_q), .sel(Rreg2), .data(Rdata2));
endmodule

// File: tb/tb_n_reg_bank.sv
// tb_n_reg_bank: directed self-checking bench for n_reg_bank
module tb_n_reg_bank;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] Wdata = '0;
  logic [4:0]  Wreg = '0;
  logic [4:0]  Rreg1 = '0;
  logic [4:0]  Rreg2 = '0;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic        RegWrite = 0;
  int          errors = 0;
  int          checks = 0;

  n_reg_bank dut (
    .clk(clk), .rst(rst), .Wdata(Wdata), .Wreg(Wreg), .Rreg1(Rreg1),
    .Rreg2(Rreg2), .Rdata1(Rdata1), .Rdata2(Rdata2), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] sq(input int i);
`ifdef REG_BANK_ZERO_REG_EN
    if (i == 0) return 32'd0;
`endif
    return (i + 2) * (i + 2);
  endfunction

  initial begin
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 32; i++) begin
      Rreg1 = 5'(i);
      #1 chk($sformatf("reset_r1[%0d]", i), Rdata1, 32'd0);
    end
    for (int i = 0; i < 32; i++) begin
      Wreg = 5'(i);
      Wdata = (i + 2) * (i + 2);
      RegWrite = 1;
      @(posedge clk);
      #1 RegWrite = 0;
      Rreg1 = 5'(i);
      #1 chk($sformatf("sweep_r1[%0d]", i), Rdata1, sq(i));
    end
    Rreg1 = 5;
    Rreg2 = 31;
    #1 chk("dual_r1_5", Rdata1, 32'd49);
    chk("dual_r2_31", Rdata2, 32'd1089);
    Rreg1 = 7;
    Rreg2 = 7;
    #1 chk("same_r1_7", Rdata1, 32'd81);
    chk("same_r2_7", Rdata2, 32'd81);
    RegWrite = 0;
    Wreg = 3;
    Wdata = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1 Rreg1 = 3;
    #1 chk("we_off_r3", Rdata1, 32'd25);
    Rreg1 = 9;
    Wreg = 9;
    Wdata = 7;
    RegWrite = 1;
    #1 chk("nobypass_before", Rdata1, 32'd121);
    @(posedge clk);
    #1 chk("nobypass_after", Rdata1, 32'd7);
    RegWrite = 0;
    rst = 1;
    RegWrite = 1;
    Wreg = 4;
    Wdata = 123;
    @(posedge clk);
    #1 rst = 0;
    RegWrite = 0;
    for (int i = 0; i < 32; i++) begin
      Rreg1 = 5'(i);
      Rreg2 = 5'(31 - i);
      #1 chk($sformatf("rstprio_r1[%0d]", i), Rdata1, 32'd0);
      chk($sformatf("rstprio_r2[%0d]", 31 - i), Rdata2, 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/n_reg_bank.md
Name: n_reg_bank

Overview:
- Parameterised multi-port register file for the single-cycle MIPS datapath: M registers, each N bits wide.
- Provides two independent combinational read ports and one synchronous write port.
- Sits between instruction decode (register specifiers) and the ALU/writeback path.

Parameters:
- N, 32, data width of each register in bits.
- M, 32, number of registers; must be a power of two and at least 2. Address width A = $clog2(M).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Wdata  input  N  write data.
- Wreg  input  A  write register address.
- Rreg1  input  A  read port 1 address.
- Rreg2  input  A  read port 2 address.
- Rdata1  output  N  read port 1 data.
- Rdata2  output  N  read port 2 data.
- RegWrite  input  1  write enable.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Storage: M registers of N bits each, all zero after reset.
- Reset:
  - On a rising clk edge with rst=1, every register is cleared to 0.
  - rst has priority over RegWrite, so a write in a reset cycle is discarded.
  - Holding rst high keeps the array zero.
- Write: on a rising clk edge with rst=0 and RegWrite=1, register[Wreg] <= Wdata. With RegWrite=0, no register changes.
- Read:
  - Purely combinational, zero latency: Rdata1 = register[Rreg1], Rdata2 = register[Rreg2].
  - Outputs have no reset of their own; they reflect the array contents, so both outputs are 0 after reset.
- Write/read same cycle, same address:
  - No bypass. Before the edge, the read returns the old value.
  - The new value appears on the read port immediately after the edge that commits it.
- Both read ports may address the same register, including the one being written; each port returns the same value.
- Address range: Wreg, Rreg1 and Rreg2 are always in range because M is a power of two. No wrap or error logic is required.
- Unknown inputs: RegWrite=X must not be relied on. Benches drive RegWrite=0 when no write is intended.

Optional Feature:
- Macro: REG_BANK_ZERO_REG_EN.
- Defined (MIPS $zero semantics):
  - Register 0 is hardwired to 0.
  - Writes with Wreg=0 are ignored.
  - Reads of address 0 return 0 regardless of write history.
- Not defined: register 0 is an ordinary writable register.

Decomposition:
- Shared package reg_bank_pkg holds:
  - default constants REG_WIDTH=32 and REG_COUNT=32;
  - derived REG_ADDR_W = $clog2(REG_COUNT);
  - typedefs reg_data_t and reg_addr_t.
- One natural sub-module: reg_bank_read_mux, an M:1 N-bit combinational selector instantiated once per read port.
- The storage array and write/reset logic live in n_reg_bank.

Test Plan:
- Reset sweep: rst=1 for one edge, then rst=0; read Rreg1 = 0..31 in turn -> Rdata1=0 for every address.
- Write-then-read sweep: for i = 0..31, write Wdata=(i+2)^2 with RegWrite=1 for one edge, then RegWrite=0.
  - Without REG_BANK_ZERO_REG_EN: Rdata1 = 4, 9, 16, ..., 1089.
  - With the macro: address 0 reads 0.
- Dual read: after the sweep, Rreg1=5 and Rreg2=31 -> Rdata1=49 and Rdata2=1089 in the same cycle. Rreg1=Rreg2=7 -> both ports read 81.
- Write enable off: RegWrite=0, Wreg=3, Wdata=0xDEAD, clock 2 edges -> register 3 keeps 25.
- Reset priority: rst=1 with RegWrite=1, Wreg=4, Wdata=123 at the edge -> register 4 reads 0 afterwards. All other registers also read 0.
- No-bypass timing: Rreg1=Wreg=9 holding 121, drive Wdata=7 with RegWrite=1.
  - Before the edge: Rdata1=121.
  - After the edge: Rdata1=7.
